// File: rtl/lab2_proc_iter_muldiv_pkg.sv
// Shared definitions for the lab2 iterative mul/div unit:
// op encodings, FSM states and req_msg field offsets.
package lab2_proc_muldiv_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  function automatic int msg_w(input int nbits);
    return 3 + 2 * nbits;
  endfunction

  function automatic int op_lsb(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic int a_lsb(input int nbits);
    return nbits;
  endfunction

  function automatic int b_lsb(input int nbits);
    return 0 * nbits;
  endfunction

endpackage

// File: rtl/lab2_proc_iter_muldiv_if.sv
// val/rdy request and response channels of the mul/div unit.
// master = requester (X stage), slave = the unit.
interface lab2_proc_iter_muldiv_if #(
  parameter int NBITS = 32
);
  import lab2_proc_muldiv_pkg::*;

  logic                      req_val;
  logic                      req_rdy;
  logic [msg_w(NBITS)-1:0]   req_msg;
  logic                      resp_val;
  logic                      resp_rdy;
  logic [NBITS-1:0]          resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/lab2_proc_iter_muldiv_ctrl.sv
// Control FSM: handshakes, iteration counter, early exit.
// Early MUL exit is enabled by LAB2_PROC_MULDIV_EARLY_EXIT_EN.
module lab2_proc_iter_muldiv_ctrl
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic req_val,
  input  logic resp_rdy,
  input  logic special,
  input  logic is_mul,
  input  logic b_next_zero,
  output logic req_rdy,
  output logic resp_val,
  output logic accept,
  output logic calc,
  output logic last
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(NBITS - 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          early;

`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
  assign early = is_mul && b_next_zero;
`else
  logic unused_ee;
  assign early     = 1'b0;
  assign unused_ee = is_mul ^ b_next_zero;
`endif

  assign req_rdy = (state == ST_IDLE) && !reset;
  assign accept  = req_val && req_rdy;
  assign calc    = (state == ST_CALC);
  assign last    = calc && ((cnt == CNT_MAX) || early);

  // State, counter and registered resp_val
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      resp_val <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            state    <= special ? ST_DONE : ST_CALC;
            resp_val <= special;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt      <= '0;
            state    <= ST_DONE;
            resp_val <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_rdy) begin
            state    <= ST_IDLE;
            resp_val <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lab2_proc_iter_muldiv.sv
// Iterative MUL/DIV/DIVU/REM/REMU unit, one bit per cycle.
// Optional: LAB2_PROC_MULDIV_EARLY_EXIT_EN (early MUL exit).
module lab2_proc_iter_muldiv
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input logic                      clk,
  input logic                      reset,
  lab2_proc_iter_muldiv_if.slave   io
);

  localparam int N      = NBITS;
  localparam int OP_LSB = op_lsb(N);
  localparam int A_LSB  = a_lsb(N);
  localparam int B_LSB  = b_lsb(N);
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  logic [2:0]   op_in;
  logic [N-1:0] a_in, b_in;
  logic         is_sdiv, is_div, is_q;
  logic         illegal, dz, ovf, special;
  logic [N-1:0] spec_val, mag_a, mag_b;

  logic [2:0]     op_q;
  logic           neg_q;
  logic [N-1:0]   a_q, b_q, res_q;
  logic [2*N-1:0] rq, rq_next;

  logic [N:0]   rem_sh, diff;
  logic [N-1:0] raw, fin;
  logic         accept, calc, last;

  assign op_in = io.req_msg[OP_LSB +: 3];
  assign a_in  = io.req_msg[A_LSB +: N];
  assign b_in  = io.req_msg[B_LSB +: N];

  // Request decode: special cases and operand magnitudes
  always_comb begin
    is_sdiv  = (op_in == OP_DIV) || (op_in == OP_REM);
    is_div   = is_sdiv || (op_in == OP_DIVU)
            || (op_in == OP_REMU);
    is_q     = (op_in == OP_DIV) || (op_in == OP_DIVU);
    illegal  = (op_in > OP_REMU);
    dz       = is_div && (b_in == '0);
    ovf      = is_sdiv && (a_in == MIN) && (b_in == '1);
    special  = illegal || dz || ovf;
    spec_val = '0;
    unique case (1'b1)
      illegal: spec_val = '0;
      dz:      spec_val = is_q ? '1 : a_in;
      ovf:     spec_val = is_q ? MIN : '0;
      default: spec_val = '0;
    endcase
    mag_a = (is_sdiv && a_in[N-1]) ? -a_in : a_in;
    mag_b = (is_sdiv && b_in[N-1]) ? -b_in : b_in;
  end

  // One iteration: shift-add or restoring-divide step
  always_comb begin
    rem_sh  = rq[2*N-1:N-1];
    diff    = rem_sh - {1'b0, a_q};
    rq_next = rq;
    if (op_q == OP_MUL)
      rq_next[N-1:0] = rq[N-1:0] + (b_q[0] ? a_q : '0);
    else if (!diff[N])
      rq_next = {diff[N-1:0], rq[N-2:0], 1'b1};
    else
      rq_next = {rem_sh[N-1:0], rq[N-2:0], 1'b0};
    raw = ((op_q == OP_REM) || (op_q == OP_REMU))
        ? rq_next[2*N-1:N] : rq_next[N-1:0];
    fin = neg_q ? -raw : raw;
  end

  // Datapath registers and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      rq    <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q <= op_in;
      b_q  <= b_in;
      if (special)
        res_q <= spec_val;
      if (op_in == OP_MUL) begin
        a_q   <= a_in;
        rq    <= '0;
        neg_q <= 1'b0;
      end else begin
        a_q   <= mag_b;
        rq    <= {{N{1'b0}}, mag_a};
        neg_q <= (op_in == OP_DIV) ? (a_in[N-1] ^ b_in[N-1])
               : (op_in == OP_REM) ? a_in[N-1] : 1'b0;
      end
    end else if (calc) begin
      rq <= rq_next;
      if (op_q == OP_MUL) begin
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end
      if (last)
        res_q <= fin;
    end
  end

  assign io.resp_msg = res_q;

  lab2_proc_iter_muldiv_ctrl #(
    .NBITS (N)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .req_val     (io.req_val),
    .resp_rdy    (io.resp_rdy),
    .special     (special),
    .is_mul      (op_q == OP_MUL),
    .b_next_zero (b_q[N-1:1] == '0),
    .req_rdy     (io.req_rdy),
    .resp_val    (io.resp_val),
    .accept      (accept),
    .calc        (calc),
    .last        (last)
  );

endmodule

// File: tb/tb_lab2_proc_iter_muldiv.sv
// Self-checking bench for lab2_proc_iter_muldiv.
// NBITS=8 when LAB2_PROC_MULDIV_EARLY_EXIT_EN is defined.
module tb_lab2_proc_iter_muldiv;

`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
  localparam int N = 8;
`else
  localparam int N = 32;
`endif
  localparam int MW = 3 + 2 * N;
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONES = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lab2_proc_iter_muldiv_if #(.NBITS(N)) io();

  lab2_proc_iter_muldiv #(.NBITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from the arithmetic definition of each op
  function automatic logic [N-1:0] model(input logic [2:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic signed [N-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a * b;
      3'd1: begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        return sa / sb;
      end
      3'd2: return (b == 0) ? ONES : a / b;
      3'd3: begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return '0;
        return sa % sb;
      end
      3'd4: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Clock edges after the accept edge until resp_val is visible
  function automatic int lat(input logic [2:0] op,
                             input logic [N-1:0] a,
                             input logic [N-1:0] b);
    int m;
    if (op > 3'd4) return 0;
    if (op != 3'd0 && b == 0) return 0;
    if ((op == 3'd1 || op == 3'd3) && a == MINV && b == ONES)
      return 0;
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
    if (op == 3'd0) begin
      m = 0;
      for (int i = 0; i < N; i++) if (b[i]) m = i;
      return m + 1;
    end
`endif
    m = N;
    return m;
  endfunction

  task automatic do_op(input logic [2:0] op,
                       input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input logic [N-1:0] exp,
                       input int exp_lat,
                       input int hold,
                       input string tag);
    int n;
    int guard;
    logic busy_bad;
    guard = 0;
    busy_bad = 1'b0;
    while (io.req_rdy !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " req_rdy"}, io.req_rdy, 1'b1);
    io.req_val = 1'b1;
    io.req_msg = {op, a, b};
    @(posedge clk);
    @(negedge clk);
    io.req_val = 1'b0;
    io.req_msg = MW'({$urandom(), $urandom(), $urandom()});
    n = 0;
    while (io.resp_val !== 1'b1 && n < N + 8) begin
      if (io.req_rdy !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_rdy"}, busy_bad, 1'b0);
    check({tag, " result"}, io.resp_msg, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold_val"}, io.resp_val, 1'b1);
      check({tag, " hold_msg"}, io.resp_msg, exp);
      check({tag, " hold_rdy"}, io.req_rdy, 1'b0);
    end
    io.resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.resp_rdy = 1'b0;
    check({tag, " val_clr"}, io.resp_val, 1'b0);
    check({tag, " rdy_back"}, io.req_rdy, 1'b1);
  endtask

  task automatic rand_op(input string tag);
    logic [2:0]   op;
    logic [N-1:0] a, b;
    int           kind;
    op   = 3'($urandom_range(0, 7));
    a    = N'($urandom());
    b    = N'($urandom());
    kind = $urandom_range(0, 7);
    if (kind == 0) b = '0;
    if (kind == 1) begin
      a = MINV;
      b = ONES;
    end
    if (kind == 2) b = N'($urandom_range(1, 9));
    if (kind == 3) a = N'($urandom_range(0, 200));
    do_op(op, a, b, model(op, a, b), lat(op, a, b), 0, tag);
  endtask

  initial begin
    int resp_seen;
    io.req_val  = 1'b0;
    io.req_msg  = '0;
    io.resp_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_rdy", io.req_rdy, 1'b0);
    check("rst resp_val", io.resp_val, 1'b0);
    check("rst resp_msg", io.resp_msg, '0);
    reset = 1'b0;
    #1;
    check("post_rst req_rdy", io.req_rdy, 1'b1);
    @(negedge clk);

`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
    do_op(3'd0, 8'd3, 8'd5, 8'd15, 3, 0, "ee mul3x5");
    do_op(3'd0, 8'd9, 8'd0, 8'd0, 1, 0, "ee mul9x0");
    do_op(3'd2, 8'd100, 8'd7, 8'd14, 8, 0, "ee divu");
`else
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32, 0, "mul");
    do_op(3'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 0, "div");
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0, "rem");
    do_op(3'd2, 32'd100, 32'd7, 32'd14, 32, 0, "divu");
    do_op(3'd4, 32'd100, 32'd7, 32'd2, 32, 0, "remu");
    do_op(3'd2, 32'h80000000, 32'd0, 32'hFFFFFFFF, 0, 0, "divu_dz");
    do_op(3'd3, 32'd5, 32'd0, 32'd5, 0, 0, "rem_dz");
    do_op(3'd6, 32'd123, 32'd45, 32'd0, 0, 0, "illegal");
    do_op(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0,
          "div_ovf");
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, "rem_ovf");
`endif

    do_op(3'd4, N'(200), N'(9), N'(200 % 9), N, 5, "bp remu");
    do_op(3'd0, N'(11), N'(6), N'(66), lat(3'd0, N'(11), N'(6)), 0,
          "b2b mul");

    for (int i = 0; i < 40; i++)
      rand_op($sformatf("rnd%0d", i));

    io.req_val = 1'b1;
    io.req_msg = {3'd2, N'($urandom()), N'(3)};
    @(posedge clk);
    @(negedge clk);
    io.req_val = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst req_rdy", io.req_rdy, 1'b0);
    check("midrst resp_val", io.resp_val, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst rdy_after", io.req_rdy, 1'b1);
    check("midrst resp_msg", io.resp_msg, '0);
    resp_seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (io.resp_val !== 1'b0) resp_seen++;
    end
    check("midrst no_resp", resp_seen, 0);

    do_op(3'd1, N'(50), N'(7), N'(7), N, 0, "after_rst div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
